// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction field bundles into 32-bit words, buffers
// them in a small FIFO and streams them into instruction memory at
// consecutive byte addresses during a start/finish-bounded load session.
module instr_encoder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        finish,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  cond,
  input  logic [1:0]  op,
  input  logic [5:0]  funct,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [23:0] imm,
  input  logic        imem_stall,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_count,
  output logic        err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [31:0]    addr_q;
  logic [15:0]    wc_q;
  logic           err_q;
  logic           done_q, done_d;

  logic           fifo_empty, fifo_full;
  logic           start_ok, hs, push, pop, illegal;
  logic [31:0]    word;

  // FIFO status; the extra pointer bit separates full from empty at wrap
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Handshake and write-port decode; in_ready uses full-before-pop
  assign start_ok = (state_q == IDLE) && start;
  assign in_ready = (state_q == RUN) && !fifo_full;
  assign hs       = in_valid && in_ready;
  assign push     = hs && (op != 2'b11);
  assign illegal  = hs && (op == 2'b11);
  assign imem_we  = (state_q != IDLE) && !fifo_empty && !imem_stall;
  assign pop      = imem_we;

  assign imem_addr  = addr_q;
  assign imem_wdata = mem_q[rd_ptr_q[AW-1:0]];
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign word_count = wc_q;
  assign err        = err_q;

  // Field packing; branches carry a 24-bit offset in place of rn/rd/src2
  always_comb begin
    word = {cond, op, funct, rn, rd, imm[11:0]};
    if (op == 2'b10) begin
      word = {cond, 2'b10, funct[5:4], imm};
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and end-of-session pulse
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (finish) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers gate reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= word;
    end
  end

  // Pointers, write address, word counter, sticky error and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= '0;
      wc_q     <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= done_d;
      if (start_ok) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        addr_q   <= base_addr;
        wc_q     <= '0;
        err_q    <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
          addr_q   <= addr_q + 32'd4;
          if (wc_q != 16'hFFFF) begin
            wc_q <= wc_q + 16'd1;
          end
        end
        if (illegal) begin
          err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a write-port scoreboard.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, finish;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rn, rd;
  logic [23:0] imm;
  logic        imem_stall;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata;
  logic        busy, done, err;
  logic [15:0] word_count;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_a;
  logic [63:0] sb_q [$];

  instr_encoder #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .finish     (finish),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cond       (cond),
    .op         (op),
    .funct      (funct),
    .rn         (rn),
    .rd         (rd),
    .imm        (imm),
    .imem_stall (imem_stall),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Pops the expected (addr, data) pair on every write strobe
  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: got addr %h data %h want no write", imem_addr, imem_wdata);
        end else begin
          e = sb_q.pop_front();
          chk("wr_addr", imem_addr, e[63:32]);
          chk("wr_data", imem_wdata, e[31:0]);
        end
      end
    end
  endtask

  task automatic do_start(input logic [31:0] a);
    start     = 1'b1;
    base_addr = a;
    @(posedge clk); #1;
    start = 1'b0;
    exp_a = a;
  endtask

  // Offers one bundle, waits (bounded) for the handshake, logs the expected write
  task automatic send(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                      input logic [3:0] n, input logic [3:0] d, input logic [23:0] im,
                      input logic [31:0] exp_w, input bit track);
    bit ok;
    cond = c; op = o; funct = f; rn = n; rd = d; imm = im;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("handshake", 32'(ok), 32'd1);
    if (ok && track && (o != 2'b11)) begin
      sb_q.push_back({exp_a, exp_w});
      exp_a = exp_a + 32'd4;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
  endtask

  initial begin
    fork
      monitor();
    join_none

    rst = 1'b1; start = 1'b0; finish = 1'b0; base_addr = '0; in_valid = 1'b0;
    cond = '0; op = '0; funct = '0; rn = '0; rd = '0; imm = '0; imem_stall = 1'b0;
    exp_a = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);

    // Session 1: start right at reset release
    @(posedge clk); #1;
    rst = 1'b0;
    do_start(32'h100);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_wc", 32'(word_count), 32'd0);

    // DP encode; no write while pushing into an empty FIFO
    cond = 4'hE; op = 2'b00; funct = 6'b001000; rn = 4'd1; rd = 4'd2; imm = 24'h000005;
    in_valid = 1'b1;
    @(negedge clk);
    chk("dp_ready", 32'(in_ready), 32'd1);
    chk("push_empty_no_we", 32'(imem_we), 32'd0);
    sb_q.push_back({32'h100, 32'hE0812005});
    exp_a = 32'h104;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("dp_latency_we", 32'(imem_we), 32'd1);
    @(posedge clk); #1;
    chk("dp_wc", 32'(word_count), 32'd1);

    // B encode; rn/rd ignored
    send(4'hE, 2'b10, 6'b100000, 4'hF, 4'hF, 24'hFFFFFE, 32'hEAFFFFFE, 1'b1);
    @(posedge clk); #1;
    chk("b_wc", 32'(word_count), 32'd2);

    // Backpressure: fill under stall; DP ignores imm[23:12]
    imem_stall = 1'b1;
    for (int k = 0; k < 4; k++)
      send(4'h1, 2'b01, 6'h3F, 4'h3, 4'h4, 24'hFFFAB0 + 24'(k), 32'h17F34AB0 + 32'(k), 1'b1);
    @(negedge clk);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("stall_no_we", 32'(imem_we), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("still_full_ready", 32'(in_ready), 32'd0);
    chk("stall_wc", 32'(word_count), 32'd2);
    @(posedge clk); #1;
    imem_stall = 1'b0;
    @(negedge clk);
    chk("release_we0", 32'(imem_we), 32'd1);
    chk("full_before_pop", 32'(in_ready), 32'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("release_we_consec", 32'(imem_we), 32'd1);
    end
    @(negedge clk);
    chk("release_we_end", 32'(imem_we), 32'd0);
    chk("release_wc", 32'(word_count), 32'd6);

    // Illegal op: consumed, nothing pushed, err sticky
    @(posedge clk); #1;
    send(4'h0, 2'b11, 6'h00, 4'h0, 4'h0, 24'h000000, 32'h0, 1'b1);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_wc", 32'(word_count), 32'd6);
    chk("ill_no_we", 32'(imem_we), 32'd0);
    send(4'h0, 2'b00, 6'h00, 4'h0, 4'h0, 24'h000123, 32'h00000123, 1'b1);
    @(posedge clk); #1;
    chk("ill_err_sticky", 32'(err), 32'd1);
    chk("ill_wc_after", 32'(word_count), 32'd7);

    // Finish with a handshake in the same cycle
    finish = 1'b1;
    send(4'h0, 2'b00, 6'h00, 4'h0, 4'h0, 24'h000456, 32'h00000456, 1'b1);
    finish = 1'b0;
    @(negedge clk);
    chk("drain_ready", 32'(in_ready), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_we", 32'(imem_we), 32'd1);
    wait_done();
    chk("s1_busy", 32'(busy), 32'd0);
    chk("s1_wc", 32'(word_count), 32'd8);
    @(negedge clk);
    chk("s1_done_pulse", 32'(done), 32'd0);

    // finish in IDLE is ignored
    @(posedge clk); #1;
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    @(negedge clk);
    chk("idle_finish_busy", 32'(busy), 32'd0);
    chk("idle_finish_done", 32'(done), 32'd0);

    // Session 2: drain 3 queued words under a 2-cycle stall
    @(posedge clk); #1;
    do_start(32'h300);
    chk("s2_err_clear", 32'(err), 32'd0);
    chk("s2_wc0", 32'(word_count), 32'd0);
    imem_stall = 1'b1;
    for (int k = 0; k < 3; k++)
      send(4'hF, 2'b00, 6'h15, 4'h5, 4'h6, 24'h00000F + 24'(k), 32'hF155600F + 32'(k), 1'b1);
    start = 1'b1;
    base_addr = 32'h999;
    @(posedge clk); #1;
    start = 1'b0;
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    @(negedge clk);
    chk("s2_drain_ready", 32'(in_ready), 32'd0);
    chk("s2_drain_busy", 32'(busy), 32'd1);
    chk("s2_stall_no_we", 32'(imem_we), 32'd0);
    @(posedge clk); #1;
    imem_stall = 1'b0;
    wait_done();
    chk("s2_wc", 32'(word_count), 32'd3);
    chk("s2_busy", 32'(busy), 32'd0);

    // Session 3: reset with 2 words pending; they must never be written
    @(posedge clk); #1;
    do_start(32'h400);
    imem_stall = 1'b1;
    send(4'h0, 2'b00, 6'h00, 4'h0, 4'h0, 24'h000777, 32'h00000777, 1'b0);
    send(4'h0, 2'b00, 6'h00, 4'h0, 4'h0, 24'h000778, 32'h00000778, 1'b0);
    imem_stall = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_we", 32'(imem_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    chk("midrst_wc", 32'(word_count), 32'd0);
    chk("midrst_addr", imem_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_start(32'h200);
    chk("s3_busy", 32'(busy), 32'd1);
    send(4'hE, 2'b00, 6'b001000, 4'd1, 4'd2, 24'h000005, 32'hE0812005, 1'b1);
    @(posedge clk); #1;
    chk("s3_wc", 32'(word_count), 32'd1);

    // Finish with an empty FIFO: DRAIN lasts one cycle
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    chk("drain1_busy", 32'(busy), 32'd1);
    chk("drain1_done0", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("drain1_done", 32'(done), 32'd1);
    chk("drain1_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("drain1_done_off", 32'(done), 32'd0);

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
